fft_butterfly_unit: RTL and testbench
=====================================

# fft_butterfly_unit

Pipelined radix-2 decimation-in-time butterfly for the 1024-point in-place FFT engine. Takes the two operands and the twiddle factor fetched by the RAM controller and produces `out_a = a + b·w` and `out_b = a − b·w` for write-back to the same addresses. It has a fixed 4-cycle latency and accepts one butterfly per cycle.

## Interface
- `DATA_W`, default 32: width of each real/imag component, giving a 64-bit complex word.
- `TW_FRAC`, default 30: fractional bits of the twiddle components (Q2.30).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  qualifies `a`, `b` and `twiddle` this cycle.
- `a`  in  64  complex operand A: `{re[63:32], im[31:0]}`, two's complement integers.
- `b`  in  64  complex operand B, same format as `a`.
- `twiddle`  in  64  complex twiddle `{cos, −sin}`, each component Q2.30 signed (1.0 = 0x40000000).
- `out_valid`  out  1  qualifies `out_a` and `out_b`.
- `out_a`  out  64  result `a + b·w`, same format as `a`.
- `out_b`  out  64  result `a − b·w`, same format as `a`.

## Operation
- **Stage 1:** register `a`, `b`, `twiddle` when `in_valid` is high.
- **Stage 2:** form the four signed 32×32 → 64-bit products `br·wr`, `bi·wi`, `br·wi`, `bi·wr`, and carry `a` forward.
- **Stage 3:** compute the 65-bit sums, then arithmetic-shift each right by `TW_FRAC` (floor, no rounding):
  - `tr = (br·wr − bi·wi) >>> 30`
  - `ti = (br·wi + bi·wr) >>> 30`
  - Keep the low 32 bits of each result (modulo 2^32).
- **Stage 4:** compute `out_a = (ar+tr, ai+ti)` and `out_b = (ar−tr, ai−ti)`:
  - All adds and subtracts are 32-bit wrap-around, with no saturation and no scaling.
  - Register the results to the outputs.
- Each stage's valid bit shifts down the pipeline every cycle.
  - Data registers of a stage load only when that stage's incoming valid is 1.
- When `in_valid` stays low, `out_a`/`out_b` hold the last result indefinitely.
  - The FFT sequencer relies on this: it latches inputs once, waits a compute window, then samples the outputs.
- No backpressure: `out_valid` must be consumed in the cycle it is high. The pipeline never stalls.

## Timing
- Latency: `in_valid` sampled high at edge N produces `out_valid` high after edge N+4, with the matching results.
- Throughput: one butterfly per cycle. Back-to-back `in_valid` gives back-to-back `out_valid` in the same order.
- `out_valid` is a 1-cycle pulse per accepted input.
- Reset (asynchronous, `rst_n` = 0):
  - All valid bits are 0 and `out_a`/`out_b` are 0 immediately, without waiting for a clock edge.
  - Internal data registers are 0.
- Reset mid-operation: in-flight butterflies are discarded and no `out_valid` is produced for them.
- The first input accepted after `rst_n` rises yields `out_valid` 4 cycles later.
- Simultaneous `in_valid` and `out_valid` is normal pipelined operation; no conflict.
- Twiddle ±1.0 (0x40000000 / 0xC0000000) must be exact: `b·1.0 = b` with no truncation error.

## Test plan
- **Reset:** assert `rst_n` = 0 with no clock running → `out_valid` = 0 and `out_a` = `out_b` = 0 immediately; after release with no input, both hold 0.
- **Unity twiddle:** `a` = (100, −5), `b` = (7, 3), `w` = (0x40000000, 0) → exactly 4 cycles later `out_a` = (107, −2), `out_b` = (93, −8).
- **−j twiddle:** same `a`, `b`, `w` = (0, 0xC0000000) → `t` = (3, −7), so `out_a` = (103, −12) and `out_b` = (97, 2).
- **Floor truncation:** `a` = (0, 0), `b` = (−3, 0), `w` = (0x20000000, 0) → `tr` = −2, so `out_a` = (−2, 0) and `out_b` = (2, 0).
- **Wrap-around:** `a` = (0x7FFFFFFF, 0), `b` = (1, 0), `w` = 1.0 → `out_a`.re = 0x80000000, `out_b`.re = 0x7FFFFFFE.
- **Throughput and reset:**
  - Stream 8 consecutive butterflies → 8 consecutive correct results starting 4 cycles after the first input.
  - Drop `rst_n` after the third input → no further `out_valid`, and outputs are 0.

Source files
------------

// File: rtl/fft_butterfly_unit_if.sv
// fft_butterfly_unit_if
//   Groups the operand/result bus of the radix-2 butterfly.
//   master : the RAM controller side; it drives operands and receives results.
//   slave  : the butterfly side; it receives operands and drives results.
// Signals (complex words are {re, im}, each half DATA_W bits):
//   in_valid  qualifies a, b and twiddle this cycle
//   a, b      complex operands, two's complement integers
//   twiddle   complex twiddle {cos, -sin}, each half signed fixed point
//   out_valid one-cycle pulse qualifying out_a / out_b
//   out_a     a + b*w
//   out_b     a - b*w
interface fft_butterfly_unit_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic [2*DATA_W-1:0]   a;
  logic [2*DATA_W-1:0]   b;
  logic [2*DATA_W-1:0]   twiddle;
  logic                  out_valid;
  logic [2*DATA_W-1:0]   out_a;
  logic [2*DATA_W-1:0]   out_b;

  modport master (
    output in_valid, a, b, twiddle,
    input  out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, a, b, twiddle,
    output out_valid, out_a, out_b
  );
endinterface

// File: rtl/fft_butterfly_unit.sv
// fft_butterfly_unit
//   Pipelined radix-2 decimation-in-time butterfly for the in-place FFT.
//   Produces out_a = a + b*w and out_b = a - b*w with a fixed latency of
//   4 cycles after the input edge, one butterfly per cycle, no stall.
//   Results hold on the outputs until the next valid result arrives.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; clears valids, data and outputs
//   bf      slave side of fft_butterfly_unit_if (operands in, results out)
// Parameters:
//   DATA_W  width of each real/imag component
//   TW_FRAC fractional bits of the twiddle components
module fft_butterfly_unit #(
  parameter int DATA_W  = 32,
  parameter int TW_FRAC = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_butterfly_unit_if.slave bf
);

  localparam int CW = 2 * DATA_W;     // complex word
  localparam int PW = 2 * DATA_W;     // full product
  localparam int SW = 2 * DATA_W + 1; // product sum with headroom

  // Stage 1: captured operands
  logic          v1;
  logic [CW-1:0] a1;
  logic [CW-1:0] b1;
  logic [CW-1:0] w1;

  // Stage 2: partial products
  logic                 v2;
  logic [CW-1:0]        a2;
  logic signed [PW-1:0] p_rr;
  logic signed [PW-1:0] p_ii;
  logic signed [PW-1:0] p_ri;
  logic signed [PW-1:0] p_ir;

  // Stage 3: full-precision product sums
  logic                 v3;
  logic [CW-1:0]        a3;
  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;

  // Stage 4: scaled twiddle product t = b*w
  logic              v4;
  logic [CW-1:0]     a4;
  logic [DATA_W-1:0] t_re;
  logic [DATA_W-1:0] t_im;

  // Output stage
  logic          out_valid_r;
  logic [CW-1:0] out_a_r;
  logic [CW-1:0] out_b_r;

  logic signed [DATA_W-1:0] b1_re;
  logic signed [DATA_W-1:0] b1_im;
  logic signed [DATA_W-1:0] w1_re;
  logic signed [DATA_W-1:0] w1_im;
  logic [DATA_W-1:0]        a4_re;
  logic [DATA_W-1:0]        a4_im;

  assign b1_re = b1[CW-1:DATA_W];
  assign b1_im = b1[DATA_W-1:0];
  assign w1_re = w1[CW-1:DATA_W];
  assign w1_im = w1[DATA_W-1:0];
  assign a4_re = a4[CW-1:DATA_W];
  assign a4_im = a4[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      w1 <= '0;
    end else begin
      v1 <= bf.in_valid;
      if (bf.in_valid) begin
        a1 <= bf.a;
        b1 <= bf.b;
        w1 <= bf.twiddle;
      end
    end
  end

  // Operands are sign-extended to the product width first so the multiply
  // is evaluated at full precision rather than at operand width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      a2   <= '0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        a2   <= a1;
        p_rr <= PW'(b1_re) * PW'(w1_re);
        p_ii <= PW'(b1_im) * PW'(w1_im);
        p_ri <= PW'(b1_re) * PW'(w1_im);
        p_ir <= PW'(b1_im) * PW'(w1_re);
      end
    end
  end

  // One extra bit of headroom so the sum of two full products cannot
  // overflow before scaling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      a3     <= '0;
      sum_re <= '0;
      sum_im <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        a3     <= a2;
        sum_re <= {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        sum_im <= {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
      end
    end
  end

  // Arithmetic shift floors toward minus infinity; only the low DATA_W bits
  // are kept, so out-of-range products wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4   <= 1'b0;
      a4   <= '0;
      t_re <= '0;
      t_im <= '0;
    end else begin
      v4 <= v3;
      if (v3) begin
        a4   <= a3;
        t_re <= DATA_W'(sum_re >>> TW_FRAC);
        t_im <= DATA_W'(sum_im >>> TW_FRAC);
      end
    end
  end

  // Outputs load only on a valid result so the sequencer can sample them
  // any time after its compute window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_a_r     <= '0;
      out_b_r     <= '0;
    end else begin
      out_valid_r <= v4;
      if (v4) begin
        out_a_r <= {a4_re + t_re, a4_im + t_im};
        out_b_r <= {a4_re - t_re, a4_im - t_im};
      end
    end
  end

  assign bf.out_valid = out_valid_r;
  assign bf.out_a     = out_a_r;
  assign bf.out_b     = out_b_r;

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// tb_fft_butterfly_unit
//   Directed bench for fft_butterfly_unit: async reset, unity / -j / -1 /
//   half twiddles, floor truncation, wrap-around, output hold, streaming
//   throughput and reset while operations are in flight.
module tb_fft_butterfly_unit;

  localparam logic [31:0] ONE     = 32'h4000_0000;
  localparam logic [31:0] NEG_ONE = 32'hC000_0000;
  localparam logic [31:0] HALF    = 32'h2000_0000;
  localparam logic [63:0] JUNK    = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  fft_butterfly_unit_if #(.DATA_W(32)) bf_if ();

  fft_butterfly_unit #(.DATA_W(32), .TW_FRAC(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bf    (bf_if)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [63:0] cx(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] wv);
    bf_if.in_valid = vld;
    bf_if.a        = av;
    bf_if.b        = bv;
    bf_if.twiddle  = wv;
  endtask

  // Called at a negedge with the pipeline idle. Checks latency, the result
  // pulse and that the result holds afterwards while junk sits on the inputs.
  task automatic send_one(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] wv, input logic [63:0] ea, input logic [63:0] eb);
    drive(1'b1, av, bv, wv);
    @(negedge clk);
    drive(1'b0, JUNK, ~JUNK, JUNK);
    repeat (3) @(negedge clk);
    check({tag, "_not_early"}, 64'(bf_if.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(bf_if.out_valid), 64'd1);
    check({tag, "_out_a"}, bf_if.out_a, ea);
    check({tag, "_out_b"}, bf_if.out_b, eb);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bf_if.out_valid), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_hold_a"}, bf_if.out_a, ea);
    check({tag, "_hold_b"}, bf_if.out_b, eb);
  endtask

  initial begin
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b1;

    // Asynchronous reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(bf_if.out_valid), 64'd0);
    check("rst_async_out_a", bf_if.out_a, 64'd0);
    check("rst_async_out_b", bf_if.out_b, 64'd0);

    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_valid", 64'(bf_if.out_valid), 64'd0);
    check("idle_out_a", bf_if.out_a, 64'd0);
    check("idle_out_b", bf_if.out_b, 64'd0);

    // t = (7, 3)
    send_one("unity", cx(100, -5), cx(7, 3), cx(ONE, 0), cx(107, -2), cx(93, -8));
    // t = (3, -7)
    send_one("minus_j", cx(100, -5), cx(7, 3), cx(0, NEG_ONE), cx(103, -12), cx(97, 2));
    // -3 * 0.5 = -1.5 floors to -2
    send_one("floor", cx(0, 0), cx(-3, 0), cx(HALF, 0), cx(-2, 0), cx(2, 0));
    send_one("wrap", cx(32'h7FFF_FFFF, 0), cx(1, 0), cx(ONE, 0),
             cx(32'h8000_0000, 0), cx(32'h7FFF_FFFE, 0));
    // t = (-7, -3)
    send_one("minus_one", cx(100, -5), cx(7, 3), cx(NEG_ONE, 0), cx(93, -8), cx(107, -2));
    // w = 0.5 + 0.5j, b = (10, 6): t = (5 - 3, 5 + 3) = (2, 8)
    send_one("half_cross", cx(1, 1), cx(10, 6), cx(HALF, HALF), cx(3, 9), cx(-1, -7));

    // Stream of 8: input k (1..8) is a = (10k, -k), b = (k, 2k),
    // w = +1 for even k and -1 for odd k.
    for (int s = 0; s < 14; s++) begin
      if (s >= 5 && s < 13) begin
        int k;
        k = s - 5 + 1;
        check($sformatf("stream%0d_valid", k), 64'(bf_if.out_valid), 64'd1);
        if (k % 2 == 0) begin
          check($sformatf("stream%0d_out_a", k), bf_if.out_a, cx(11 * k, k));
          check($sformatf("stream%0d_out_b", k), bf_if.out_b, cx(9 * k, -3 * k));
        end else begin
          check($sformatf("stream%0d_out_a", k), bf_if.out_a, cx(9 * k, -3 * k));
          check($sformatf("stream%0d_out_b", k), bf_if.out_b, cx(11 * k, k));
        end
      end else begin
        check($sformatf("stream_gap%0d_valid", s), 64'(bf_if.out_valid), 64'd0);
      end
      if (s < 8) begin
        int k;
        k = s + 1;
        drive(1'b1, cx(10 * k, -k), cx(k, 2 * k), cx((k % 2 == 0) ? ONE : NEG_ONE, 0));
      end else begin
        drive(1'b0, JUNK, JUNK, JUNK);
      end
      @(negedge clk);
    end

    // Reset with three butterflies in flight
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, cx(50 + s, 1), cx(2, 2), cx(ONE, 0));
      @(negedge clk);
    end
    drive(1'b0, JUNK, JUNK, JUNK);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bf_if.out_valid), 64'd0);
    check("midrst_out_a", bf_if.out_a, 64'd0);
    check("midrst_out_b", bf_if.out_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      check($sformatf("midrst_flush%0d_valid", s), 64'(bf_if.out_valid), 64'd0);
    end
    check("midrst_after_out_a", bf_if.out_a, 64'd0);
    check("midrst_after_out_b", bf_if.out_b, 64'd0);

    send_one("post_rst", cx(100, -5), cx(7, 3), cx(ONE, 0), cx(107, -2), cx(93, -8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
